tlb_lookup: RTL and testbench
=============================

# tlb_lookup

Fully-associative translation lookaside buffer that serves the requesting side of the TLB miss-handling interface. It translates 32-bit virtual addresses to physical addresses from a small cached page table. On a miss it raises `tlb_miss_detected` with the faulting address, then stalls until the miss handler returns a translation on `tlb_update`/`physical_address`. It sits between the core's memory stage and the miss handler; it installs the returned translation and then completes the stalled request.

## Interface
- `ENTRIES`, 8, number of TLB entries (power of two, ≥2)
- `PAGE_BITS`, 12, page offset width; VPN = `va[31:PAGE_BITS]`, PPN = `pa[31:PAGE_BITS]`

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  translation request
- `req_vaddr`  in  32  virtual address to translate
- `req_ready`  out  1  request accepted on an edge where `req_valid & req_ready`
- `resp_valid`  out  1  one-cycle pulse, translation result valid
- `resp_paddr`  out  32  translated physical address
- `resp_hit`  out  1  1 = served from TLB; 0 = served after fill
- `tlb_miss_detected`  out  1  miss request to the handler, level, held until fill
- `virtual_address`  out  32  faulting address, stable while `tlb_miss_detected`=1
- `tlb_update`  in  1  fill strobe from the handler
- `physical_address`  in  32  fill translation; only PPN bits are used
- `flush`  in  1  invalidate all entries (present only with `TLB_FLUSH_EN`)

## Operation
- States: IDLE, MISS. `req_ready` = (state == IDLE).
- IDLE, request accepted:
  - VPN is compared against all valid entries combinationally.
  - Hit → register `resp_paddr` = {PPN, `req_vaddr[PAGE_BITS-1:0]`}, `resp_hit`=1, `resp_valid`=1; stay in IDLE.
  - Miss → latch `req_vaddr` into `virtual_address`, set `tlb_miss_detected`=1, go to MISS.
- MISS, on `tlb_update`=1:
  - Write {valid=1, VPN of `virtual_address`, PPN of `physical_address`} into the victim entry.
  - Register `resp_paddr` = {fill PPN, `virtual_address[PAGE_BITS-1:0]`}, `resp_hit`=0, `resp_valid`=1.
  - Clear `tlb_miss_detected`; go to IDLE.
- `tlb_update` in IDLE is ignored; no table write occurs.
- Victim selection: lowest-index invalid entry if one exists. Otherwise a round-robin pointer is used; it increments after each replacement and wraps from ENTRIES-1 to 0.
- Multiple matching entries cannot arise, since fills occur only on misses.
- Reset: all valid bits 0, round-robin pointer 0, state IDLE. Reset values of outputs:
  - `resp_valid`=0, `resp_paddr`=0, `resp_hit`=0
  - `tlb_miss_detected`=0, `virtual_address`=0
  - `req_ready`=1 (combinational from state)
- Reset during MISS aborts the miss: no response is produced, and a later `tlb_update` is ignored.

## Timing
- Hit latency: request accepted at edge N → `resp_valid` high for the cycle after N, with `resp_paddr` valid in the same cycle.
- Back-to-back hits: one request per cycle; `req_ready` stays high.
- Miss: `tlb_miss_detected` is high from the cycle after acceptance edge N until the fill edge M.
- Fill: if `tlb_update` is sampled at edge M, `resp_valid` is high in the cycle after M; `req_ready` is high again in that same cycle.
- `tlb_update` may be asserted in the very first MISS cycle; the minimum miss penalty is then 1 cycle beyond a hit.
- `resp_valid` is exactly one cycle wide; there is no backpressure on the response.

## Configuration
- `TLB_FLUSH_EN` defined: the `flush` port exists.
  - `flush`=1 at an edge clears every valid bit and resets the round-robin pointer to 0.
  - A lookup accepted at the same edge as `flush` uses the pre-flush contents.
  - If `flush` and a MISS-state `tlb_update` share an edge, the flush applies first and the fill is then written to entry 0. The response is produced normally.
  - `flush` does not abort a pending miss.
- `TLB_FLUSH_EN` undefined: no `flush` port; valid bits are cleared only by `reset`.

## Test plan
- Reset, then request `req_vaddr`=0x00002abc:
  - Expect a miss: `tlb_miss_detected`=1, `virtual_address`=0x00002abc.
  - Drive `tlb_update`=1, `physical_address`=0x00005000.
  - Expect one `resp_valid` pulse with `resp_paddr`=0x00005abc, `resp_hit`=0.
- After the first scenario, request 0x00002010 → `resp_valid` in the next cycle, `resp_paddr`=0x00005010, `resp_hit`=1, `tlb_miss_detected` stays 0.
- Fill 9 distinct pages (VPN 1..9) with ENTRIES=8:
  - The 9th fill replaces entry 0 (VPN 1).
  - Re-request VPN 1 → miss; VPN 2 → hit.
- Pulse `tlb_update` while in IDLE with 0x0000f000, then request a new VPN → miss still raised and the table is unchanged.
- Assert `reset` while in MISS → `tlb_miss_detected`=0 immediately (asynchronous). A subsequent `tlb_update` produces no `resp_valid`, and a previously filled VPN now misses.
- With `TLB_FLUSH_EN`: fill VPN 2, pulse `flush`, then request VPN 2 → miss raised. A `flush` coincident with a fill still responds with `resp_hit`=0 and leaves the entry valid.

Source files
------------

// File: rtl/tlb_lookup.sv
// Fully-associative TLB. A hit responds one cycle after acceptance. A miss stalls in MISS until the handler fills.
// Optional TLB_FLUSH_EN adds a flush port that invalidates every entry.
module tlb_lookup #(
    parameter int ENTRIES   = 8,
    parameter int PAGE_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_hit,
    output logic        tlb_miss_detected,
    output logic [31:0] virtual_address,
    input  logic        tlb_update,
    input  logic [31:0] physical_address
`ifdef TLB_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic {S_IDLE = 1'b0, S_MISS = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_vpn [ENTRIES];
    logic [VPN_W-1:0]   r_ppn [ENTRIES];
    logic [IDX_W-1:0]   r_rr;
    logic               r_resp_valid;
    logic [31:0]        r_resp_paddr;
    logic               r_resp_hit;
    logic [31:0]        r_vaddr;

    logic               w_flush;
    logic               w_accept;
    logic               w_fill;
    logic               w_hit;
    logic [VPN_W-1:0]   w_hit_ppn;
    logic               w_has_free;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_victim;
    logic [VPN_W-1:0]   w_req_vpn;
    logic [VPN_W-1:0]   w_fill_ppn;
    logic               w_unused;

`ifdef TLB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept   = req_valid & req_ready;
    assign w_fill     = (r_state == S_MISS) & tlb_update;
    assign w_req_vpn  = req_vaddr[31:PAGE_BITS];
    assign w_fill_ppn = physical_address[31:PAGE_BITS];
    assign w_unused   = ^physical_address[PAGE_BITS-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == w_req_vpn)) begin
                w_hit     = 1'b1;
                w_hit_ppn = r_ppn[i];
            end
        end
    end

    // Descending scan so the lowest-index free entry is the one that sticks.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // A flush sharing the edge with a fill empties the table first, so the fill lands in entry 0.
    assign w_victim = w_flush ? '0 : (w_has_free ? w_free_idx : r_rr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_hit) w_state_nxt = S_MISS;
            S_MISS:  if (tlb_update)         w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready         = (r_state == S_IDLE);
        tlb_miss_detected = (r_state == S_MISS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_rr    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_vpn[i] <= '0;
                r_ppn[i] <= '0;
            end
        end else begin
            if (w_flush) begin
                r_valid <= '0;
                r_rr    <= '0;
            end
            if (w_fill) begin
                r_valid[w_victim] <= 1'b1;
                r_vpn[w_victim]   <= r_vaddr[31:PAGE_BITS];
                r_ppn[w_victim]   <= w_fill_ppn;
                if (!w_flush && !w_has_free) r_rr <= r_rr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_paddr <= '0;
            r_resp_hit   <= 1'b0;
            r_vaddr      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept && w_hit) begin
                r_resp_valid <= 1'b1;
                r_resp_paddr <= {w_hit_ppn, req_vaddr[PAGE_BITS-1:0]};
                r_resp_hit   <= 1'b1;
            end else if (w_accept) begin
                r_vaddr      <= req_vaddr;
            end else if (w_fill) begin
                r_resp_valid <= 1'b1;
                r_resp_paddr <= {w_fill_ppn, r_vaddr[PAGE_BITS-1:0]};
                r_resp_hit   <= 1'b0;
            end
        end
    end

    assign resp_valid      = r_resp_valid;
    assign resp_paddr      = r_resp_paddr;
    assign resp_hit        = r_resp_hit;
    assign virtual_address = r_vaddr;

endmodule

// File: tb/tb_tlb_lookup.sv
// Directed bench for tlb_lookup: fill/hit paths, round-robin replacement, idle fill strobes, async reset and optional flush.
module tb_tlb_lookup;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_vaddr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_hit;
    logic        tlb_miss_detected;
    logic [31:0] virtual_address;
    logic        tlb_update = 1'b0;
    logic [31:0] physical_address = '0;
`ifdef TLB_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_lookup #(.ENTRIES(8), .PAGE_BITS(12)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_vaddr         (req_vaddr),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_paddr        (resp_paddr),
        .resp_hit          (resp_hit),
        .tlb_miss_detected (tlb_miss_detected),
        .virtual_address   (virtual_address),
        .tlb_update        (tlb_update),
        .physical_address  (physical_address)
`ifdef TLB_FLUSH_EN
        ,
        .flush             (flush)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_hit(input string tag, input logic [31:0] va, input logic [31:0] exp_pa);
        req_valid = 1'b1;
        req_vaddr = va;
        tick();
        req_valid = 1'b0;
        chk({tag, ".vld"},  resp_valid, 1);
        chk({tag, ".pa"},   resp_paddr, exp_pa);
        chk({tag, ".hit"},  resp_hit, 1);
        chk({tag, ".miss"}, tlb_miss_detected, 0);
    endtask

    task automatic request_miss(input string tag, input logic [31:0] va);
        req_valid = 1'b1;
        req_vaddr = va;
        tick();
        req_valid = 1'b0;
        chk({tag, ".miss"}, tlb_miss_detected, 1);
        chk({tag, ".va"},   virtual_address, va);
        chk({tag, ".vld"},  resp_valid, 0);
        chk({tag, ".rdy"},  req_ready, 0);
    endtask

    task automatic fill(input string tag, input logic [31:0] pa, input logic [31:0] exp_pa);
        tlb_update       = 1'b1;
        physical_address = pa;
        tick();
        tlb_update       = 1'b0;
        chk({tag, ".fvld"},  resp_valid, 1);
        chk({tag, ".fpa"},   resp_paddr, exp_pa);
        chk({tag, ".fhit"},  resp_hit, 0);
        chk({tag, ".fmiss"}, tlb_miss_detected, 0);
        chk({tag, ".frdy"},  req_ready, 1);
    endtask

    task automatic do_reset;
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst.rdy",  req_ready, 1);
        chk("rst.vld",  resp_valid, 0);
        chk("rst.pa",   resp_paddr, 0);
        chk("rst.hit",  resp_hit, 0);
        chk("rst.miss", tlb_miss_detected, 0);
        chk("rst.va",   virtual_address, 0);

        request_miss("m1", 32'h0000_2abc);
        fill("m1", 32'h0000_5000, 32'h0000_5abc);
        tick();
        chk("m1.pulse", resp_valid, 0);

        lookup_hit("h1", 32'h0000_2010, 32'h0000_5010);

        // back-to-back hits with req_valid held
        req_valid = 1'b1;
        req_vaddr = 32'h0000_2111;
        tick();
        chk("b2b.pa0",  resp_paddr, 32'h0000_5111);
        chk("b2b.rdy0", req_ready, 1);
        req_vaddr = 32'h0000_2222;
        tick();
        req_valid = 1'b0;
        chk("b2b.vld1", resp_valid, 1);
        chk("b2b.pa1",  resp_paddr, 32'h0000_5222);

        // VPN 1..9 into an 8-entry table: VPN n -> PPN 0x10+n
        do_reset();
        for (int v = 1; v <= 9; v++) begin
            request_miss($sformatf("rr%0d", v), 32'(v) << 12);
            fill($sformatf("rr%0d", v), (32'h10 + 32'(v)) << 12, (32'h10 + 32'(v)) << 12);
        end
        lookup_hit("rr.v2", 32'h0000_2044, 32'h0001_2044);
        lookup_hit("rr.v9", 32'h0000_9088, 32'h0001_9088);
        request_miss("rr.v1", 32'h0000_1004);
        fill("rr.v1", 32'h0001_1000, 32'h0001_1004);
        // pointer advanced to entry 1, so the VPN 1 refill evicted VPN 2
        request_miss("rr.v2b", 32'h0000_2008);
        fill("rr.v2b", 32'h0001_2000, 32'h0001_2008);
        lookup_hit("rr.v4", 32'h0000_4abc, 32'h0001_4abc);

        // fill strobe in IDLE must be ignored
        tlb_update       = 1'b1;
        physical_address = 32'h0000_f000;
        tick();
        tlb_update       = 1'b0;
        chk("idle.vld", resp_valid, 0);
        chk("idle.rdy", req_ready, 1);
        request_miss("idle.new", 32'h0000_a123);
        fill("idle.new", 32'h0003_3000, 32'h0003_3123);
        lookup_hit("idle.v9", 32'h0000_9001, 32'h0001_9001);

        // asynchronous reset during MISS
        request_miss("ar", 32'h0000_b000);
        #2 reset = 1'b1;
        #1;
        chk("ar.miss", tlb_miss_detected, 0);
        chk("ar.rdy",  req_ready, 1);
        chk("ar.va",   virtual_address, 0);
        tick();
        reset = 1'b0;
        tlb_update       = 1'b1;
        physical_address = 32'h0004_4000;
        tick();
        tlb_update       = 1'b0;
        chk("ar.upd", resp_valid, 0);
        request_miss("ar.v9", 32'h0000_9001);
        fill("ar.v9", 32'h0001_9000, 32'h0001_9001);

`ifdef TLB_FLUSH_EN
        do_reset();
        request_miss("fl.a", 32'h0000_2000);
        fill("fl.a", 32'h0000_5000, 32'h0000_5000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        request_miss("fl.b", 32'h0000_2345);
        flush = 1'b1;
        fill("fl.b", 32'h0000_6000, 32'h0000_6345);
        flush = 1'b0;
        lookup_hit("fl.c", 32'h0000_2777, 32'h0000_6777);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
